front_panel_encoders: RTL and testbench

Parametrised multi-channel front-panel encoder interface, successor to the single-encoder front-panel block. It synchronises, debounces and quadrature-decodes NUM_ENC rotary encoders with push switches, accumulates a signed detent count per channel, and latches switch and error events. It exposes a read-select/strobe CPU register interface with clear-on-read and a level interrupt.

---
 rtl/front_panel_encoders.sv | 203 ++++++++++++++++++++
 tb/tb_front_panel_encoders.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/front_panel_encoders.sv
// Multi-channel rotary encoder front panel: synchronise, debounce and quadrature-decode
// NUM_ENC encoders with push switches; saturating detent counters behind a clear-on-read port.
module front_panel_encoders #(
  parameter int NUM_ENC             = 2,
  parameter int CNT_WIDTH           = 8,
  parameter int DEBOUNCE_CYCLES     = 1024,
  parameter int QUARTERS_PER_DETENT = 4,
  parameter int SW_ACTIVE_LOW       = 1,
  localparam int SEL_W  = (NUM_ENC > 1) ? $clog2(NUM_ENC) : 1,
  localparam int WORD_W = CNT_WIDTH + 5
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [NUM_ENC-1:0] encoder_A,
  input  logic [NUM_ENC-1:0] encoder_B,
  input  logic [NUM_ENC-1:0] encoder_sw,
  input  logic [SEL_W-1:0]   rd_sel,
  input  logic               rd_stb,
  output logic [WORD_W-1:0]  rd_data,
  output logic               irq
);

  localparam int                     DB_W    = $clog2(DEBOUNCE_CYCLES);
  localparam logic [DB_W-1:0]        DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic signed [3:0]      Q_LIMIT = 4'(QUARTERS_PER_DETENT);
  localparam logic [CNT_WIDTH-1:0]   D_MAX   = {1'b0, {(CNT_WIDTH-1){1'b1}}};
  localparam logic [CNT_WIDTH-1:0]   D_MIN   = {1'b1, {(CNT_WIDTH-1){1'b0}}};
  localparam logic                   SW_INV  = (SW_ACTIVE_LOW != 0);
  localparam int                     IN_SW   = 2;

  // Field order matches the upper bits of the read word, MSB first.
  typedef struct packed {
    logic err;
    logic ovf;
    logic rot;
    logic press;
  } flags_t;

  // Per channel, bit 0 = A, bit 1 = B, bit 2 = switch.
  logic [2:0]            sync1_q   [NUM_ENC];
  logic [2:0]            sync1_d   [NUM_ENC];
  logic [2:0]            sync2_q   [NUM_ENC];
  logic [2:0]            sync2_d   [NUM_ENC];
  logic [2:0]            deb_q     [NUM_ENC];
  logic [2:0]            deb_d     [NUM_ENC];
  logic [2:0]            init_q    [NUM_ENC];
  logic [2:0]            init_d    [NUM_ENC];
  logic [DB_W-1:0]       cnt_q     [NUM_ENC][3];
  logic [DB_W-1:0]       cnt_d     [NUM_ENC][3];
  logic [1:0]            prev_ab_q [NUM_ENC];
  logic [1:0]            prev_ab_d [NUM_ENC];
  logic signed [3:0]     q_q       [NUM_ENC];
  logic signed [3:0]     q_d       [NUM_ENC];
  logic [CNT_WIDTH-1:0]  delta_q   [NUM_ENC];
  logic [CNT_WIDTH-1:0]  delta_d   [NUM_ENC];
  flags_t                flags_q   [NUM_ENC];
  flags_t                flags_d   [NUM_ENC];
  logic [NUM_ENC-1:0]    live_q, live_d;
  logic [NUM_ENC-1:0]    pressed_q, pressed_d;
  logic [WORD_W-1:0]     rd_data_q, rd_data_d;
  logic                  irq_q, irq_d;

  // Position around the Gray cycle 00,01,11,10 so a step is a modulo-4 difference.
  function automatic logic [1:0] gray_pos(input logic [1:0] ba);
    return {ba[1], ba[1] ^ ba[0]};
  endfunction

  always_comb begin : next_state
    logic [1:0]           step;
    logic signed [3:0]    q_next;
    logic                 up, dn, bad, rd_hit, pressed_now;
    logic [CNT_WIDTH-1:0] delta_next;
    flags_t               flags_next;

    // NOTE: every variable gets a default before any branch so no path can infer a latch.
    step        = '0;
    q_next      = '0;
    up          = 1'b0;
    dn          = 1'b0;
    bad         = 1'b0;
    rd_hit      = 1'b0;
    pressed_now = 1'b0;
    delta_next  = '0;
    flags_next  = '0;
    live_d      = '0;
    pressed_d   = '0;
    irq_d       = 1'b0;
    rd_data_d   = rd_stb ? '0 : rd_data_q;

    for (int i = 0; i < NUM_ENC; i++) begin
      sync1_d[i] = {encoder_sw[i], encoder_B[i], encoder_A[i]};
      sync2_d[i] = sync1_q[i];
      deb_d[i]   = deb_q[i];
      init_d[i]  = init_q[i];

      for (int j = 0; j < 3; j++) begin
        cnt_d[i][j] = '0;
        if (!init_q[i][j]) begin
          // Until the first settle, follow the sample and wait for it to hold still.
          if (sync2_q[i][j] != deb_q[i][j])  deb_d[i][j]  = sync2_q[i][j];
          else if (cnt_q[i][j] == DB_LAST)   init_d[i][j] = 1'b1;
          else                               cnt_d[i][j]  = cnt_q[i][j] + DB_W'(1);
        end else if (sync2_q[i][j] != deb_q[i][j]) begin
          if (cnt_q[i][j] == DB_LAST) deb_d[i][j] = sync2_q[i][j];
          else                        cnt_d[i][j] = cnt_q[i][j] + DB_W'(1);
        end
      end

      // Decoding starts one cycle after every input of the channel has settled.
      live_d[i]    = &init_q[i];
      prev_ab_d[i] = deb_q[i][1:0];
      step         = gray_pos(deb_q[i][1:0]) - gray_pos(prev_ab_q[i]);
      q_next       = q_q[i];
      up           = 1'b0;
      dn           = 1'b0;
      bad          = 1'b0;
      if (live_q[i]) begin
        case (step)
          2'd1:    q_next = q_q[i] + 4'sd1;
          2'd3:    q_next = q_q[i] - 4'sd1;
          2'd2:    bad    = 1'b1;
          default: ;
        endcase
      end
      if (bad) begin
        q_next = '0;
      end else if (q_next == Q_LIMIT) begin
        up     = 1'b1;
        q_next = '0;
      end else if (q_next == -Q_LIMIT) begin
        dn     = 1'b1;
        q_next = '0;
      end
      q_d[i] = q_next;

      // A read clears first; an event in the same cycle then lands on the cleared state.
      rd_hit      = rd_stb && (rd_sel == SEL_W'(i));
      delta_next  = rd_hit ? '0 : delta_q[i];
      flags_next  = rd_hit ? '0 : flags_q[i];
      pressed_now = deb_q[i][IN_SW] ^ SW_INV;
      pressed_d[i] = init_q[i][IN_SW] & pressed_now;

      if (live_q[i] && pressed_now && !pressed_q[i]) flags_next.press = 1'b1;
      if (bad)      flags_next.err = 1'b1;
      if (up || dn) flags_next.rot = 1'b1;
      if (up) begin
        if (delta_next == D_MAX) flags_next.ovf = 1'b1;
        else                     delta_next     = delta_next + CNT_WIDTH'(1);
      end
      if (dn) begin
        if (delta_next == D_MIN) flags_next.ovf = 1'b1;
        else                     delta_next     = delta_next - CNT_WIDTH'(1);
      end
      delta_d[i] = delta_next;
      flags_d[i] = flags_next;

      if (rd_hit) rd_data_d = {flags_q[i], pressed_q[i], delta_q[i]};
      irq_d = irq_d | (|flags_q[i]);
    end
  end

  // NOTE: sequential state is written only with non-blocking assignments.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      // NOTE: these per-channel arrays are plain flops, so all of them take the reset.
      for (int i = 0; i < NUM_ENC; i++) begin
        sync1_q[i]   <= '0;
        sync2_q[i]   <= '0;
        deb_q[i]     <= '0;
        init_q[i]    <= '0;
        prev_ab_q[i] <= '0;
        q_q[i]       <= '0;
        delta_q[i]   <= '0;
        flags_q[i]   <= '0;
        for (int j = 0; j < 3; j++) cnt_q[i][j] <= '0;
      end
      live_q    <= '0;
      pressed_q <= '0;
      rd_data_q <= '0;
      irq_q     <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_ENC; i++) begin
        sync1_q[i]   <= sync1_d[i];
        sync2_q[i]   <= sync2_d[i];
        deb_q[i]     <= deb_d[i];
        init_q[i]    <= init_d[i];
        prev_ab_q[i] <= prev_ab_d[i];
        q_q[i]       <= q_d[i];
        delta_q[i]   <= delta_d[i];
        flags_q[i]   <= flags_d[i];
        for (int j = 0; j < 3; j++) cnt_q[i][j] <= cnt_d[i][j];
      end
      live_q    <= live_d;
      pressed_q <= pressed_d;
      rd_data_q <= rd_data_d;
      irq_q     <= irq_d;
    end
  end

  assign rd_data = rd_data_q;
  assign irq     = irq_q;

endmodule

// File: tb/tb_front_panel_encoders.sv
// Bench for front_panel_encoders: a per-cycle behavioural model compared on every
// cycle, plus hand-computed read words for each scenario.
module tb_front_panel_encoders;

  localparam int NUM_ENC = 2;
  localparam int CNT_W   = 8;
  localparam int DEB     = 4;
  localparam int QPD     = 4;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  enc_a, enc_b, enc_sw;
  logic [0:0]  rd_sel;
  logic        rd_stb;
  logic [12:0] rd_data;
  logic        irq;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  front_panel_encoders #(
    .NUM_ENC(NUM_ENC), .CNT_WIDTH(CNT_W), .DEBOUNCE_CYCLES(DEB),
    .QUARTERS_PER_DETENT(QPD), .SW_ACTIVE_LOW(1)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .encoder_A(enc_a), .encoder_B(enc_b), .encoder_sw(enc_sw),
    .rd_sel(rd_sel), .rd_stb(rd_stb), .rd_data(rd_data), .irq(irq)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got 0x%0h, want 0x%0h", name, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Each pin is seen two edges late; the debounced level takes the delayed sample once
  // that sample has held one value, different from the debounced one, for DEB edges.
  int m_p1 [2][3], m_p2 [2][3], m_last [2][3], m_run [2][3], m_deb [2][3], m_seen [2][3];
  int m_q [2], m_delta [2];
  bit m_press [2], m_rot [2], m_ovf [2], m_err [2], m_pressed [2];
  int m_rd;
  bit m_irq;
  bit model_on = 1'b0;
  int pos_of [4] = '{0, 1, 3, 2};
  int mv_d, mv_s, mv_irq;
  bit mv_np;

  function automatic int pin_of(input int ch, input int j);
    if (j == 0) return int'(enc_a[ch]);
    if (j == 1) return int'(enc_b[ch]);
    return int'(enc_sw[ch]);
  endfunction

  function automatic int word_of(input int ch);
    return (m_delta[ch] & 255) | (int'(m_pressed[ch]) << 8) | (int'(m_press[ch]) << 9) |
           (int'(m_rot[ch]) << 10) | (int'(m_ovf[ch]) << 11) | (int'(m_err[ch]) << 12);
  endfunction

  task automatic detent(input int ch, input int dir);
    m_rot[ch] = 1'b1;
    if (dir > 0 && m_delta[ch] == 127)       m_ovf[ch] = 1'b1;
    else if (dir < 0 && m_delta[ch] == -128) m_ovf[ch] = 1'b1;
    else                                     m_delta[ch] += dir;
  endtask

  always @(posedge clk) begin
    if (!reset_n) begin
      for (int ch = 0; ch < 2; ch++) begin
        for (int j = 0; j < 3; j++) begin
          m_p1[ch][j] = pin_of(ch, j);  m_p2[ch][j] = pin_of(ch, j);
          m_last[ch][j] = pin_of(ch, j); m_deb[ch][j] = pin_of(ch, j);
          m_seen[ch][j] = pin_of(ch, j); m_run[ch][j] = 0;
        end
        m_q[ch] = 0; m_delta[ch] = 0;
        m_press[ch] = 0; m_rot[ch] = 0; m_ovf[ch] = 0; m_err[ch] = 0;
        m_pressed[ch] = (pin_of(ch, 2) == 0);
      end
      m_rd = 0; m_irq = 0;
    end else begin
      mv_irq = 0;
      for (int ch = 0; ch < 2; ch++)
        if (m_press[ch] || m_rot[ch] || m_ovf[ch] || m_err[ch]) mv_irq = 1;
      if (rd_stb) m_rd = (int'(rd_sel) < NUM_ENC) ? word_of(int'(rd_sel)) : 0;
      m_irq = (mv_irq != 0);
      for (int ch = 0; ch < 2; ch++) begin
        if (rd_stb && int'(rd_sel) == ch) begin
          m_delta[ch] = 0; m_press[ch] = 0; m_rot[ch] = 0; m_ovf[ch] = 0; m_err[ch] = 0;
        end
        mv_d = (pos_of[m_deb[ch][1]*2 + m_deb[ch][0]] -
                pos_of[m_seen[ch][1]*2 + m_seen[ch][0]] + 4) % 4;
        if (mv_d == 2) begin
          m_err[ch] = 1'b1; m_q[ch] = 0;
        end else begin
          if (mv_d == 1) m_q[ch]++;
          if (mv_d == 3) m_q[ch]--;
          if (m_q[ch] == QPD)  begin detent(ch, 1);  m_q[ch] = 0; end
          if (m_q[ch] == -QPD) begin detent(ch, -1); m_q[ch] = 0; end
        end
        mv_np = (m_deb[ch][2] == 0);
        if (mv_np && !m_pressed[ch]) m_press[ch] = 1'b1;
        m_pressed[ch] = mv_np;
        for (int j = 0; j < 3; j++) begin
          m_seen[ch][j] = m_deb[ch][j];
          mv_s = m_p2[ch][j];
          m_run[ch][j] = (mv_s == m_last[ch][j]) ? m_run[ch][j] + 1 : 1;
          m_last[ch][j] = mv_s;
          if (mv_s != m_deb[ch][j] && m_run[ch][j] >= DEB) m_deb[ch][j] = mv_s;
          m_p2[ch][j] = m_p1[ch][j];
          m_p1[ch][j] = pin_of(ch, j);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (model_on) begin
      check("rd_data_vs_model", 32'(rd_data), 32'(m_rd));
      check("irq_vs_model", 32'(irq), 32'(m_irq));
    end
  end

  // ---------------- stimulus ----------------
  task automatic set_ab(input int ch, input logic [1:0] ba, input int hold);
    enc_b[ch] = ba[1];
    enc_a[ch] = ba[0];
    repeat (hold) @(negedge clk);
  endtask

  task automatic read_chk(input int ch, input logic [31:0] exp, input string name);
    rd_sel = 1'(ch);
    rd_stb = 1'b1;
    @(negedge clk);
    rd_stb = 1'b0;
    check(name, 32'(rd_data), exp);
  endtask

  task automatic cw_cycle(input int ch, input int hold);
    set_ab(ch, 2'b10, hold); set_ab(ch, 2'b00, hold);
    set_ab(ch, 2'b01, hold); set_ab(ch, 2'b11, hold);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    enc_a = 2'b11; enc_b = 2'b11; enc_sw = 2'b11;
    rd_sel = '0; rd_stb = 1'b0; reset_n = 1'b0;
    repeat (5) @(negedge clk);
    reset_n  = 1'b1;
    model_on = 1'b1;

    // Idle pins after reset produce nothing.
    repeat (50) @(negedge clk);
    check("init_irq", 32'(irq), 32'h0);
    read_chk(0, 32'h000, "init_read_ch0");

    // Three clockwise detents on ch1, then the irq falls two cycles after the strobe.
    repeat (3) cw_cycle(1, 10);
    check("cw_irq_high", 32'(irq), 32'h1);
    read_chk(1, 32'h403, "cw_read_ch1");
    check("cw_irq_still_high", 32'(irq), 32'h1);
    @(negedge clk);
    check("cw_irq_fell", 32'(irq), 32'h0);
    read_chk(1, 32'h000, "cw_reread_ch1");

    // 130 counter-clockwise detents saturate at -128 with overflow.
    for (int n = 0; n < 130; n++) begin
      set_ab(0, 2'b01, 8); set_ab(0, 2'b00, 8);
      set_ab(0, 2'b10, 8); set_ab(0, 2'b11, 8);
    end
    read_chk(0, 32'hC80, "ccw_sat_ch0");
    for (int n = 0; n < 3; n++) begin
      enc_a[0] = 1'b0;
      repeat (3) @(negedge clk);
      enc_a[0] = 1'b1;
      repeat (8) @(negedge clk);
    end
    check("glitch_irq", 32'(irq), 32'h0);
    read_chk(0, 32'h000, "glitch_read_ch0");

    // Both bits changing at once flag an error and leave delta alone.
    cw_cycle(0, 10);
    set_ab(0, 2'b00, 10);
    set_ab(0, 2'b11, 10);
    read_chk(0, 32'h1401, "err_read_ch0");
    read_chk(0, 32'h000, "err_cleared_ch0");

    // Read strobe in the very cycle the ch1 detent lands.
    set_ab(1, 2'b10, 10); set_ab(1, 2'b00, 10); set_ab(1, 2'b01, 10);
    enc_b[1] = 1'b1; enc_a[1] = 1'b1;
    repeat (6) @(negedge clk);
    read_chk(1, 32'h000, "race_pre_event");
    repeat (10) @(negedge clk);
    read_chk(1, 32'h401, "race_post_event");

    // Switch press on ch0; reading ch1 must not touch ch0.
    enc_sw[0] = 1'b0;
    repeat (12) @(negedge clk);
    read_chk(1, 32'h000, "press_read_ch1");
    read_chk(0, 32'h300, "press_read_ch0");
    read_chk(0, 32'h100, "press_held_ch0");
    enc_sw[0] = 1'b1;
    repeat (12) @(negedge clk);
    read_chk(0, 32'h000, "release_ch0");

    // Reset mid-rotation on ch1 discards the partial quarter count.
    set_ab(1, 2'b10, 10); set_ab(1, 2'b00, 2);
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (20) @(negedge clk);
    check("reset_rd_data", 32'(rd_data), 32'h0);
    set_ab(1, 2'b01, 10); set_ab(1, 2'b11, 10);
    read_chk(1, 32'h000, "reset_q_discarded");
    cw_cycle(1, 10);
    read_chk(1, 32'h401, "reset_then_detent");

    repeat (4) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
